// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// ALU operation, ALU B-source and PC source selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_WB_R     = 4'd8,
      S_EXEC_I   = 4'd9,
      S_WB_I     = 4'd10,
      S_BRANCH   = 4'd11,
`ifdef MC_JUMP_EN
      S_JUMP     = 4'd12,
`endif
      S_FAULT    = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts waiting cycles, flags expiry on the
// TIMEOUT-th consecutive waiting cycle.
module mc_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && !expired)
         count <= count + 1'b1;
   end

   // count holds the number of waiting cycles already completed
   assign expired = (count >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM (Moore outputs, with mem_ready/zero gating).
// Optional macro MC_JUMP_EN enables the JUMP state for opcode 000010.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned OPW     = 6,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           run,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           pc_write,
   output logic           pc_write_cond,
   output logic           ir_write,
   output logic           i_or_d,
   output logic           mem_read,
   output logic           mem_write,
   output logic           reg_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     alu_op,
   output logic [1:0]     pc_src,
   output logic [3:0]     state_o,
   output logic           busy,
   output logic           instr_done,
   output logic           fault
);

   state_t state, next;
   logic   waiting, expired;
   state_t end_next;

   assign waiting  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign end_next = run ? S_FETCH : S_IDLE;

   mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!waiting || mem_ready),
      .inc     (waiting && !mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= next;
   end

   always_comb begin
      next          = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_src        = PC_ALU;
      instr_done    = 1'b0;

      unique case (state)
         S_IDLE: if (run) next = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready)    next = S_DECODE;
            else if (expired) next = S_FAULT;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OPW'(OP_RTYPE): next = S_EXEC_R;
               OPW'(OP_LW),
               OPW'(OP_SW):    next = S_MEM_ADDR;
               OPW'(OP_ADDI):  next = S_EXEC_I;
               OPW'(OP_BEQ):   next = S_BRANCH;
`ifdef MC_JUMP_EN
               OPW'(OP_J):     next = S_JUMP;
`endif
               default:        next = S_FAULT;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            next      = (opcode == OPW'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready)    next = S_MEM_WB;
            else if (expired) next = S_FAULT;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            next       = end_next;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               next       = end_next;
            end else if (expired) begin
               next = S_FAULT;
            end
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            next      = S_WB_R;
         end
         S_WB_R: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            next       = end_next;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            next      = S_WB_I;
         end
         S_WB_I: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            next       = end_next;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_src        = PC_ALUOUT;
            pc_write_cond = 1'b1;
            pc_write      = zero;
            instr_done    = 1'b1;
            next          = end_next;
         end
`ifdef MC_JUMP_EN
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
            next       = end_next;
         end
`endif
         S_FAULT: next = S_FAULT;
         default: next = S_FAULT;
      endcase
   end

   assign state_o = state;
   assign busy    = (state != S_IDLE);
   assign fault   = (state == S_FAULT);

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Param OPW, default 6: opcode width.
REQ-002 Param TIMEOUT, default 16: maximum cycles spent in a memory wait state before fault.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 run  in  1  level; permits fetch of next instruction.
REQ-006 opcode  in  OPW  from instruction register.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory ack for the current read/write.
REQ-009 pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath controls.
REQ-010 alu_src_b  out  2; alu_op  out  2 (00 add, 01 sub, 10 funct); pc_src  out  2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-011 state_o  out  4  current state code; busy  out  1; instr_done  out  1  one-cycle pulse; fault  out  1  sticky.

Function
REQ-012 Moore FSM; all control outputs decode from the state register only, except ir_write/pc_write in FETCH and pc_write_cond gating, which are ANDed with mem_ready or zero as stated below.
REQ-013 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, FAULT.
REQ-014 IDLE -> FETCH when run=1; otherwise hold; busy=0 only in IDLE.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; -> DECODE on mem_ready, else hold.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 000000->EXEC_R, 100011/101011->MEM_ADDR, 001000->EXEC_I, 000100->BRANCH, 000010->JUMP (REQ-027), other->FAULT.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEM_RD (lw) or MEM_WR (sw).
REQ-018 MEM_RD: mem_read=1, i_or_d=1; -> MEM_WB on mem_ready. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-019 MEM_WR: mem_write=1, i_or_d=1; instruction ends on mem_ready.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R: reg_write=1, reg_dst=1. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_I: reg_write=1, reg_dst=0.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1; pc_write asserted for the cycle iff zero=1.
REQ-022 Instruction end (MEM_WB, MEM_WR+ready, WB_R, WB_I, BRANCH, JUMP): instr_done=1 for that cycle; next state FETCH if run=1 else IDLE.
REQ-023 Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready; increments each waiting cycle; reaching TIMEOUT without mem_ready -> FAULT. mem_ready on the TIMEOUT cycle wins.
REQ-024 FAULT: all controls 0, fault=1, busy=1; exit only by reset. run deasserted mid-instruction does not abort it.

Reset
REQ-025 rst_n=0 forces state IDLE, wait counter 0, all outputs 0 (state_o=IDLE code 0) immediately, independent of clk.
REQ-026 Reset mid-instruction abandons it; no write strobe is asserted in the cycle rst_n rises.

Configuration
REQ-027 Macro MC_JUMP_EN: defined -> opcode 000010 enters JUMP (pc_write=1, pc_src=10), then ends; undefined -> JUMP state absent, 000010 -> FAULT.

Structure
REQ-028 Package mc_ctrl_pkg holds state encodings, opcode constants, alu_op and pc_src codes.
REQ-029 One sub-module mc_wait_timer implements the REQ-023 counter (clear, inc, expired).

Verification
REQ-030 Reset then run=1, opcode=000000, mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_R; instr_done on cycle 4, reg_write=1 with reg_dst=1.
REQ-031 lw (100011) with mem_ready low 3 cycles in MEM_RD -> hold MEM_RD 4 cycles, then MEM_WB with mem_to_reg=1.
REQ-032 beq (000100) zero=1 -> pc_write=1, pc_src=01 in BRANCH; zero=0 -> pc_write=0.
REQ-033 mem_ready held 0 in FETCH for 16 cycles -> FAULT, fault=1 until rst_n pulsed low.
REQ-034 opcode 111111 -> FAULT; opcode 000010 -> JUMP with MC_JUMP_EN, FAULT without.
REQ-035 rst_n low mid-MEM_WR -> mem_write drops asynchronously, state_o=0.
